uart_mmio_bridge: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_mmio_bridge.sv | 129 ++++++++++++
 tb/tb_uart_mmio_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO bridge: register offsets, STATUS/IE bit
// positions and the transmit handshake state encoding.
package uart_pkg;

    localparam logic [3:0] ADDR_TXD    = 4'h0;
    localparam logic [3:0] ADDR_RXD    = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_IE     = 4'hC;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_FULL   = 2;
    localparam int ST_TX_IDLE   = 3;
    localparam int ST_OVERRUN   = 4;

    localparam int IE_RX = 0;
    localparam int IE_TX = 1;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive from the count.
module uart_sync_fifo #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 3
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  count
);

    logic [DATA_W-1:0]  mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    // Count never exceeds the depth, so its MSB alone marks full.
    assign full    = count[FIFO_AW];
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sysclk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// CPU-side register front end for the UART core with TX/RX FIFOs.
// Optional level interrupt and IE register are built when UART_IRQ_EN is defined.
module uart_mmio_bridge
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 3
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic        we,
    input  logic        rd,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic [7:0]  UART_RXD,
    input  logic        RX_EFF,
    output logic        RX_READ,
    output logic [7:0]  UART_TXD,
    output logic        TX_EN,
    input  logic        TX_STATUS
);

    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       tx_dout, rx_dout;
    logic [FIFO_AW:0] tx_count, rx_count;
    tx_state_t        tx_state;
    logic             overrun, overrun_clr, tx_idle;
    logic [1:0]       ie;
    logic [31:0]      status;
    logic             unused;

    assign tx_push     = sel & we & (addr == ADDR_TXD);
    assign rx_pop      = sel & rd & (addr == ADDR_RXD);
    assign overrun_clr = sel & we & (addr == ADDR_STATUS) & wdata[ST_OVERRUN];
    // RX_READ guard keeps the byte from being taken twice while RX_EFF falls.
    assign rx_push     = RX_EFF & ~RX_READ & ~rx_full;
    assign tx_pop      = (tx_state == TX_IDLE) & ~tx_empty & TX_STATUS;
    assign tx_idle     = tx_empty & (tx_state == TX_IDLE);
    assign unused      = ^{wdata[31:8], tx_count, rx_count};

    uart_sync_fifo #(.DATA_W(8), .FIFO_AW(FIFO_AW)) u_tx_fifo (
        .sysclk(sysclk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .din(wdata[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    uart_sync_fifo #(.DATA_W(8), .FIFO_AW(FIFO_AW)) u_rx_fifo (
        .sysclk(sysclk), .reset(reset), .push(rx_push), .pop(rx_pop),
        .din(UART_RXD), .dout(rx_dout), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    always_comb begin
        status               = '0;
        status[ST_RX_NEMPTY] = ~rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_IDLE]   = tx_idle;
        status[ST_OVERRUN]   = overrun;
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                ADDR_RXD:    if (!rx_empty) rdata = {24'h0, rx_dout};
                ADDR_STATUS: rdata = status;
                ADDR_IE:     rdata = {30'h0, ie};
                default:     ;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            RX_READ <= 1'b0;
            overrun <= 1'b0;
        end else begin
            RX_READ <= rx_push;
            // A new overrun in the same cycle wins over a CPU clear.
            if (RX_EFF && rx_full) overrun <= 1'b1;
            else if (overrun_clr)  overrun <= 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            TX_EN    <= 1'b0;
            UART_TXD <= 8'h00;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_pop) begin
                    UART_TXD <= tx_dout;
                    TX_EN    <= 1'b1;
                    tx_state <= TX_REQ;
                end
                TX_REQ: if (!TX_STATUS) begin
                    TX_EN    <= 1'b0;
                    tx_state <= TX_BUSY;
                end
                TX_BUSY: if (TX_STATUS) tx_state <= TX_IDLE;
                default: begin
                    TX_EN    <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ie  <= '0;
            irq <= 1'b0;
        end else begin
            if (sel && we && (addr == ADDR_IE)) ie <= wdata[1:0];
            irq <= (ie[IE_RX] & ~rx_empty) | (ie[IE_TX] & tx_idle);
        end
    end
`else
    assign ie  = '0;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge with sender/receiver models and byte scoreboards.
module tb_uart_mmio_bridge;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0, we = 1'b0, rd = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  UART_RXD = 8'h00;
    logic        RX_EFF = 1'b0;
    logic        RX_READ;
    logic [7:0]  UART_TXD;
    logic        TX_EN;
    logic        TX_STATUS = 1'b1;

    int total = 0;
    int bad = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] feedq[$];
    int tx_sent = 0, rx_pulses = 0, low_cnt = 0, req_cnt = 0;
    bit stall = 1'b0;
    logic prev_read = 1'b0;

    uart_mmio_bridge #(.FIFO_AW(3)) dut (
        .sysclk(sysclk), .reset(reset), .sel(sel), .addr(addr), .we(we), .rd(rd),
        .wdata(wdata), .rdata(rdata), .irq(irq), .UART_RXD(UART_RXD), .RX_EFF(RX_EFF),
        .RX_READ(RX_READ), .UART_TXD(UART_TXD), .TX_EN(TX_EN), .TX_STATUS(TX_STATUS)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sender: accepts after TX_EN has been seen for 3 cycles, then stays busy 20 cycles.
    always @(negedge sysclk) begin
        if (!reset) begin
            TX_STATUS = 1'b1; low_cnt = 0; req_cnt = 0;
        end else if (stall) begin
            TX_STATUS = 1'b0;
        end else if (low_cnt > 0) begin
            low_cnt--;
            if (low_cnt == 0) TX_STATUS = 1'b1;
        end else if (TX_EN && TX_STATUS) begin
            req_cnt++;
            if (req_cnt == 3) begin
                req_cnt = 0;
                if (txq.size() > 0) chk("tx_byte", {24'h0, UART_TXD}, {24'h0, txq.pop_front()});
                else chk("tx_extra_byte", 32'(txq.size()), 32'd1);
                tx_sent++;
                TX_STATUS = 1'b0;
                low_cnt = 20;
            end
        end else begin
            req_cnt = 0;
            TX_STATUS = 1'b1;
        end
    end

    // Receiver core: presents queued bytes, drops RX_EFF the cycle after RX_READ.
    always @(negedge sysclk) begin
        if (!reset) RX_EFF = 1'b0;
        else if (RX_EFF && RX_READ) RX_EFF = 1'b0;
        else if (!RX_EFF && feedq.size() > 0) begin
            UART_RXD = feedq.pop_front();
            RX_EFF = 1'b1;
        end
    end

    always @(negedge sysclk) begin
        if (RX_READ) begin
            rx_pulses++;
            chk("rx_read_width", {31'h0, prev_read}, 32'h0);
        end
        prev_read = RX_READ;
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge sysclk); sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge sysclk); sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic rdreg(input logic [3:0] a, output logic [31:0] d);
        @(negedge sysclk); sel = 1'b1; rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge sysclk); sel = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_rx_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge sysclk); #1;
            if (!RX_EFF && feedq.size() == 0 && !RX_READ) ok = 1'b1;
        end
        chk("rx_idle_timeout", {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_tx_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge sysclk); #1;
            if (txq.size() == 0 && TX_STATUS && !TX_EN && low_cnt == 0) ok = 1'b1;
        end
        chk("tx_done_timeout", {31'h0, ok}, 32'h1);
        repeat (3) @(negedge sysclk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int p0, s0;
        bit ok;

        // Reset state
        repeat (3) @(negedge sysclk);
        #1;
        chk("rst_tx_en", {31'h0, TX_EN}, 32'h0);
        chk("rst_rx_read", {31'h0, RX_READ}, 32'h0);
        chk("rst_uart_txd", {24'h0, UART_TXD}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge sysclk); reset = 1'b1;
        repeat (2) @(negedge sysclk);
        addr = 4'h8; #1;
        chk("rdata_unselected", rdata, 32'h0);
        rdreg(4'h8, d); chk("rst_status", d, 32'h8);

        // Two TX bytes through the sender handshake
        txq.push_back(8'h41); wr(4'h0, 32'h41);
        txq.push_back(8'h42); wr(4'h0, 32'h42);
        wait_tx_done(200);
        chk("t1_sent", 32'(tx_sent), 32'd2);
        rdreg(4'h8, d); chk("t1_status", d, 32'h8);

        // Single RX byte
        p0 = rx_pulses;
        rxq.push_back(8'h5A); feedq.push_back(8'h5A);
        wait_rx_idle(50);
        chk("t2_pulses", 32'(rx_pulses - p0), 32'd1);
        rdreg(4'h8, d); chk("t2_status_nempty", d, 32'h9);
        rdreg(4'h4, d); chk("t2_rxd", d, {24'h0, rxq.pop_front()});
        rdreg(4'h8, d); chk("t2_status_empty", d, 32'h8);

        // RX overrun with nine bytes
        p0 = rx_pulses;
        for (int i = 0; i < 9; i++) begin
            feedq.push_back(8'h30 + 8'(i)); rxq.push_back(8'h30 + 8'(i));
        end
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge sysclk);
            if (rx_pulses - p0 >= 8) ok = 1'b1;
        end
        repeat (6) @(negedge sysclk);
        chk("t3_pulses_8", 32'(rx_pulses - p0), 32'd8);
        rdreg(4'h8, d); chk("t3_status_ovr", d, 32'h1B);
        wr(4'h8, 32'h10);
        rdreg(4'h8, d); chk("t3_set_beats_clear", d, 32'h1B);
        rdreg(4'h4, d); chk("t3_rxd_first", d, {24'h0, rxq.pop_front()});
        wait_rx_idle(50);
        chk("t3_pulses_9", 32'(rx_pulses - p0), 32'd9);
        rdreg(4'h8, d); chk("t3_status_full_again", d, 32'h1B);
        wr(4'h8, 32'h10);
        rdreg(4'h8, d); chk("t3_ovr_cleared", d, 32'h0B);
        for (int i = 0; i < 8; i++) begin
            rdreg(4'h4, d); chk("t3_rxd_drain", d, {24'h0, rxq.pop_front()});
        end
        rdreg(4'h8, d); chk("t3_status_end", d, 32'h8);

        // TX FIFO fill while the sender is stalled
        s0 = tx_sent;
        @(negedge sysclk); stall = 1'b1;
        repeat (2) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            txq.push_back(8'hC0 + 8'(i)); wr(4'h0, 32'hC0 + 32'(i));
        end
        rdreg(4'h8, d); chk("t4_tx_full", d, 32'h4);
        wr(4'h0, 32'hEE);
        rdreg(4'h8, d); chk("t4_tx_full_after_drop", d, 32'h4);
        @(negedge sysclk); stall = 1'b0;
        wait_tx_done(600);
        chk("t4_sent_8", 32'(tx_sent - s0), 32'd8);
        rdreg(4'h8, d); chk("t4_status_end", d, 32'h8);

        // Empty read and simultaneous push/pop
        rdreg(4'h4, d); chk("t5_empty_read", d, 32'h0);
        chk("t5_empty_count", 32'(dut.rx_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            feedq.push_back(8'hA1 + 8'(i)); rxq.push_back(8'hA1 + 8'(i));
        end
        wait_rx_idle(50);
        chk("t5_count3", 32'(dut.rx_count), 32'd3);
        feedq.push_back(8'hA4); rxq.push_back(8'hA4);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge sysclk); #1;
            if (RX_EFF) ok = 1'b1;
        end
        chk("t5_eff_timeout", {31'h0, ok}, 32'h1);
        sel = 1'b1; rd = 1'b1; addr = 4'h4; #1;
        chk("t5_same_cycle_rxd", rdata, {24'h0, rxq.pop_front()});
        @(negedge sysclk); sel = 1'b0; rd = 1'b0; #1;
        chk("t5_count_kept", 32'(dut.rx_count), 32'd3);
        wait_rx_idle(20);
        for (int i = 0; i < 3; i++) begin
            rdreg(4'h4, d); chk("t5_rxd_drain", d, {24'h0, rxq.pop_front()});
        end

        // Interrupt
        wr(4'hC, 32'h1);
        rdreg(4'hC, d);
`ifdef UART_IRQ_EN
        chk("t6_ie_read", d, 32'h1);
`else
        chk("t6_ie_read", d, 32'h0);
`endif
        rxq.push_back(8'h77); feedq.push_back(8'h77);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge sysclk); #1;
            if (!dut.rx_empty) ok = 1'b1;
        end
        chk("t6_nempty_timeout", {31'h0, ok}, 32'h1);
        chk("t6_irq_lag", {31'h0, irq}, 32'h0);
        @(negedge sysclk); #1;
`ifdef UART_IRQ_EN
        chk("t6_irq_set", {31'h0, irq}, 32'h1);
`else
        chk("t6_irq_tied", {31'h0, irq}, 32'h0);
`endif
        rdreg(4'h4, d); chk("t6_rxd", d, {24'h0, rxq.pop_front()});
        repeat (2) @(negedge sysclk); #1;
        chk("t6_irq_clear", {31'h0, irq}, 32'h0);

        // Reset while a byte is being requested
        s0 = tx_sent;
        txq.push_back(8'h99); wr(4'h0, 32'h99);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge sysclk); #1;
            if (TX_EN) ok = 1'b1;
        end
        chk("t6_tx_en_timeout", {31'h0, ok}, 32'h1);
        reset = 1'b0; #1;
        chk("t6_rst_tx_en", {31'h0, TX_EN}, 32'h0);
        chk("t6_rst_irq", {31'h0, irq}, 32'h0);
        chk("t6_rst_txd", {24'h0, UART_TXD}, 32'h0);
        txq.delete();
        @(negedge sysclk); reset = 1'b1;
        repeat (60) @(negedge sysclk);
        chk("t6_byte_not_resent", 32'(tx_sent - s0), 32'd0);
        rdreg(4'h8, d); chk("t6_status_after_rst", d, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
